// File: rtl/rst_seq_debounce_if.sv
// rtl/rst_seq_debounce_if.sv - reset request inputs and staged reset/debug outputs of rst_seq_debounce
interface rst_seq_debounce_if;
    logic       btn_rst;
    logic       sw_rst_req;
    logic       periph_rst_n;
    logic       core_rst_n;
    logic       rst_busy;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;

    modport master (
        output btn_rst, sw_rst_req,
        input  periph_rst_n, core_rst_n, rst_busy, rst_cause, rst_count
    );

    modport slave (
        input  btn_rst, sw_rst_req,
        output periph_rst_n, core_rst_n, rst_busy, rst_cause, rst_count
    );
endinterface

// File: rtl/rst_seq_debounce.sv
// rtl/rst_seq_debounce.sv - button debounce plus staged peripheral/core reset sequencer with cause tracking
module rst_seq_debounce #(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int HOLD_CYCLES      = 64,
    parameter int STAGE_GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    rst_seq_debounce_if.slave bus
);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SEQ_MAX = (HOLD_CYCLES > STAGE_GAP_CYCLES) ? HOLD_CYCLES : STAGE_GAP_CYCLES;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(HOLD_CYCLES - 1);
    localparam logic [SEQ_W-1:0] GAP_LAST  = SEQ_W'(STAGE_GAP_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_BTN = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_PERIPH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    logic [1:0]      sync_q;
    logic            btn_stable;
    logic [DB_W-1:0] db_cnt;
    logic            press_q;

    state_t          state_q, state_d;
    logic [SEQ_W-1:0] cnt_q, cnt_d;
    logic [1:0]      cause_q, cause_d;
    logic [7:0]      count_q, count_d;
    logic            event_accepted;

    logic            periph_rst_n_q;
    logic            core_rst_n_q;
    logic            rst_busy_q;

    // press_q fires on the same edge btn_stable commits a rising level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= 2'b00;
            btn_stable <= 1'b0;
            db_cnt     <= '0;
            press_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.btn_rst};
            press_q <= 1'b0;
            if (sync_q[1] == btn_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_stable <= sync_q[1];
                db_cnt     <= '0;
                press_q    <= sync_q[1];
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cause_d        = cause_q;
        count_d        = count_q;
        event_accepted = 1'b0;
        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    if (!btn_stable) begin
                        state_d = ST_PERIPH;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PERIPH: begin
                // software requests are dropped here: the core is still held in reset
                if (press_q) begin
                    state_d        = ST_HOLD;
                    cnt_d          = '0;
                    cause_d        = CAUSE_BTN;
                    event_accepted = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (press_q || bus.sw_rst_req) begin
                    state_d        = ST_HOLD;
                    cnt_d          = '0;
                    cause_d        = press_q ? CAUSE_BTN : CAUSE_SW;
                    event_accepted = 1'b1;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
        endcase
        if (event_accepted && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    // outputs are registered from the next state so they change on the transition edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_HOLD;
            cnt_q          <= '0;
            cause_q        <= CAUSE_POR;
            count_q        <= 8'd0;
            periph_rst_n_q <= 1'b0;
            core_rst_n_q   <= 1'b0;
            rst_busy_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cause_q        <= cause_d;
            count_q        <= count_d;
            periph_rst_n_q <= (state_d != ST_HOLD);
            core_rst_n_q   <= (state_d == ST_RUN);
            rst_busy_q     <= (state_d != ST_RUN);
        end
    end

    assign bus.periph_rst_n = periph_rst_n_q;
    assign bus.core_rst_n   = core_rst_n_q;
    assign bus.rst_busy     = rst_busy_q;
    assign bus.rst_cause    = cause_q;
    assign bus.rst_count    = count_q;
endmodule

// File: tb/tb_rst_seq_debounce.sv
// tb/tb_rst_seq_debounce.sv - directed bench for rst_seq_debounce with small debounce/hold/gap values
module tb_rst_seq_debounce;
    localparam int DEB  = 8;
    localparam int HOLD = 4;
    localparam int GAP  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    rst_seq_debounce_if bus ();

    rst_seq_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .STAGE_GAP_CYCLES(GAP)
    ) dut (
        .clk    (clk),
        .reset_n(rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic stayed_high;
        bus.btn_rst    = 1'b0;
        bus.sw_rst_req = 1'b0;

        // reset values
        tick(3);
        chk("rst_periph", {7'd0, bus.periph_rst_n}, 8'd0);
        chk("rst_core",   {7'd0, bus.core_rst_n},   8'd0);
        chk("rst_busy",   {7'd0, bus.rst_busy},     8'd1);
        chk("rst_cause",  {6'd0, bus.rst_cause},    8'd0);
        chk("rst_count",  bus.rst_count,            8'd0);

        // power-on staged release
        rst_n = 1'b1;
        tick(3);
        chk("por_periph_e3", {7'd0, bus.periph_rst_n}, 8'd0);
        tick(1);
        chk("por_periph_e4", {7'd0, bus.periph_rst_n}, 8'd1);
        chk("por_core_e4",   {7'd0, bus.core_rst_n},   8'd0);
        tick(2);
        chk("por_core_e6",   {7'd0, bus.core_rst_n},   8'd0);
        tick(1);
        chk("por_core_e7",   {7'd0, bus.core_rst_n},   8'd1);
        chk("por_busy_e7",   {7'd0, bus.rst_busy},     8'd0);
        chk("por_cause",     {6'd0, bus.rst_cause},    8'd0);

        // glitch rejection: 5-cycle pulses are shorter than the debounce window
        stayed_high = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.btn_rst = ((i % 10) < 5);
            tick(1);
            stayed_high = stayed_high & bus.periph_rst_n & bus.core_rst_n;
        end
        bus.btn_rst = 1'b0;
        tick(10);
        stayed_high = stayed_high & bus.periph_rst_n & bus.core_rst_n;
        chk("glitch_no_drop", {7'd0, stayed_high}, 8'd1);
        chk("glitch_count",   bus.rst_count,       8'd0);

        // valid press held 30 cycles
        bus.btn_rst = 1'b1;
        tick(10);
        chk("btn_periph_e10", {7'd0, bus.periph_rst_n}, 8'd1);
        tick(1);
        chk("btn_periph_e11", {7'd0, bus.periph_rst_n}, 8'd0);
        chk("btn_core_e11",   {7'd0, bus.core_rst_n},   8'd0);
        chk("btn_busy_e11",   {7'd0, bus.rst_busy},     8'd1);
        tick(19);
        bus.btn_rst = 1'b0;
        tick(10);
        chk("btn_held_e40",   {7'd0, bus.periph_rst_n}, 8'd0);
        tick(1);
        chk("btn_periph_e41", {7'd0, bus.periph_rst_n}, 8'd1);
        chk("btn_core_e41",   {7'd0, bus.core_rst_n},   8'd0);
        tick(2);
        chk("btn_core_e43",   {7'd0, bus.core_rst_n},   8'd0);
        tick(1);
        chk("btn_core_e44",   {7'd0, bus.core_rst_n},   8'd1);
        chk("btn_cause",      {6'd0, bus.rst_cause},    8'd1);
        chk("btn_count",      bus.rst_count,            8'd1);

        // software reset, second request during PERIPH is ignored
        bus.sw_rst_req = 1'b1;
        tick(1);
        bus.sw_rst_req = 1'b0;
        chk("sw_periph_e1", {7'd0, bus.periph_rst_n}, 8'd0);
        chk("sw_core_e1",   {7'd0, bus.core_rst_n},   8'd0);
        tick(3);
        chk("sw_periph_e4", {7'd0, bus.periph_rst_n}, 8'd0);
        tick(1);
        chk("sw_periph_e5", {7'd0, bus.periph_rst_n}, 8'd1);
        bus.sw_rst_req = 1'b1;
        tick(1);
        bus.sw_rst_req = 1'b0;
        chk("sw_ignored_e6", {7'd0, bus.periph_rst_n}, 8'd1);
        tick(1);
        chk("sw_core_e7",   {7'd0, bus.core_rst_n},   8'd0);
        tick(1);
        chk("sw_core_e8",   {7'd0, bus.core_rst_n},   8'd1);
        chk("sw_cause",     {6'd0, bus.rst_cause},    8'd2);
        chk("sw_count",     bus.rst_count,            8'd2);

        // simultaneous press event and software request
        bus.btn_rst = 1'b1;
        tick(10);
        bus.sw_rst_req = 1'b1;
        tick(1);
        bus.sw_rst_req = 1'b0;
        bus.btn_rst    = 1'b0;
        chk("both_periph", {7'd0, bus.periph_rst_n}, 8'd0);
        chk("both_cause",  {6'd0, bus.rst_cause},    8'd1);
        chk("both_count",  bus.rst_count,            8'd3);
        tick(10);
        chk("both_periph_e21", {7'd0, bus.periph_rst_n}, 8'd0);
        tick(1);
        chk("both_periph_e22", {7'd0, bus.periph_rst_n}, 8'd1);
        chk("both_core_e22",   {7'd0, bus.core_rst_n},   8'd0);

        // asynchronous reset during PERIPH
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_periph", {7'd0, bus.periph_rst_n}, 8'd0);
        chk("async_busy",   {7'd0, bus.rst_busy},     8'd1);
        chk("async_cause",  {6'd0, bus.rst_cause},    8'd0);
        chk("async_count",  bus.rst_count,            8'd0);

        // count saturation
        tick(2);
        rst_n = 1'b1;
        tick(7);
        chk("sat_run", {7'd0, bus.rst_busy}, 8'd0);
        for (int i = 0; i < 256; i++) begin
            bus.sw_rst_req = 1'b1;
            tick(1);
            bus.sw_rst_req = 1'b0;
            tick(7);
            if (i == 254) chk("sat_count_255", bus.rst_count, 8'd255);
        end
        chk("sat_count_hold", bus.rst_count,         8'd255);
        chk("sat_cause",      {6'd0, bus.rst_cause}, 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
